// File: rtl/hdmi_timing_gen_if.sv
// Video timing bundle between the timing generator and the HDMI PHY / overlay logic.
// The generator drives the video side; the consumer drives the run/pattern controls.
interface hdmi_timing_gen_if #(
    parameter int CW = 12
);
    logic          enable;
    logic [1:0]    mode;
    logic [23:0]   solid_rgb;
    logic [23:0]   data;
    logic          h_sync;
    logic          v_sync;
    logic          data_en;
    logic          clk_out;
    logic [CW-1:0] px_x;
    logic [CW-1:0] px_y;
    logic          frame_start;
    logic          line_start;

    modport master (
        input  enable, mode, solid_rgb,
        output data, h_sync, v_sync, data_en, clk_out, px_x, px_y, frame_start, line_start
    );

    modport slave (
        output enable, mode, solid_rgb,
        input  data, h_sync, v_sync, data_en, clk_out, px_x, px_y, frame_start, line_start
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Parametrised video timing and test-pattern generator feeding the HDMI PHY.
// Raster counters drive registered syncs, data enable, coordinates, strobes and pattern data.
module hdmi_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    hdmi_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HS0     = H_SYNC + H_BP;
    localparam int VS0     = V_SYNC + V_BP;
    // Guard against a zero bar width on very narrow test builds.
    localparam int BW      = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
    localparam logic [CW-1:0] HS0_C    = CW'(HS0);
    localparam logic [CW-1:0] VS0_C    = CW'(VS0);
    localparam logic [CW-1:0] HE0_C    = CW'(HS0 + H_ACTIVE);
    localparam logic [CW-1:0] VE0_C    = CW'(VS0 + V_ACTIVE);
    localparam logic [CW-1:0] BW_C     = CW'(BW);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [1:0]    mode_q;
    logic [23:0]   rgb_q;

    logic          active;
    logic          frame_first;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] bar;
    logic [23:0]   pix;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    assign vid.clk_out = clk;

    always_comb begin
        active      = (h_cnt >= HS0_C) && (h_cnt < HE0_C) && (v_cnt >= VS0_C) && (v_cnt < VE0_C);
        frame_first = (h_cnt == '0) && (v_cnt == '0);
        x           = active ? (h_cnt - HS0_C) : '0;
        y           = active ? (v_cnt - VS0_C) : '0;
        bar         = x / BW_C;
        pix         = '0;
        case (mode_q)
            2'd0: pix = rgb_q;
            2'd1: pix = (bar >= CW'(7)) ? 24'h000000 : bar_colour(bar[2:0]);
            2'd2: pix = {x[7:0], x[7:0], x[7:0]};
            2'd3: pix = (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
            default: pix = '0;
        endcase
        if (!active) begin
            pix = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            mode_q          <= '0;
            rgb_q           <= '0;
            vid.data        <= '0;
            vid.h_sync      <= ~HS_POL;
            vid.v_sync      <= ~VS_POL;
            vid.data_en     <= 1'b0;
            vid.px_x        <= '0;
            vid.px_y        <= '0;
            vid.frame_start <= 1'b0;
            vid.line_start  <= 1'b0;
        end else if (!vid.enable) begin
            // Captured pattern is kept; it reloads at (0,0) once enable returns.
            h_cnt           <= '0;
            v_cnt           <= '0;
            vid.data        <= '0;
            vid.h_sync      <= ~HS_POL;
            vid.v_sync      <= ~VS_POL;
            vid.data_en     <= 1'b0;
            vid.px_x        <= '0;
            vid.px_y        <= '0;
            vid.frame_start <= 1'b0;
            vid.line_start  <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            if (frame_first) begin
                mode_q <= vid.mode;
                rgb_q  <= vid.solid_rgb;
            end
            vid.h_sync      <= (h_cnt < H_SYNC_C) ? HS_POL : ~HS_POL;
            vid.v_sync      <= (v_cnt < V_SYNC_C) ? VS_POL : ~VS_POL;
            vid.data_en     <= active;
            vid.data        <= pix;
            vid.px_x        <= x;
            vid.px_y        <= y;
            vid.frame_start <= frame_first;
            vid.line_start  <= (h_cnt == '0);
        end
    end
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Randomised bench: two generator builds checked cycle-by-cycle against a raster-position model.
// Build a uses the small 22x7 timing; build b is wider/taller with inverted sync polarity.
module tb_hdmi_timing_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  md;
    logic [23:0] rgb;

    always #5 clk = ~clk;

    hdmi_timing_gen_if #(.CW(12)) bus_a ();
    hdmi_timing_gen_if #(.CW(12)) bus_b ();

    hdmi_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (bus_a)
    );

    hdmi_timing_gen #(
        .H_ACTIVE(64), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(40), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (bus_b)
    );

    int cfg_ha[2]  = '{16, 64};
    int cfg_hf[2]  = '{2, 2};
    int cfg_hsy[2] = '{2, 2};
    int cfg_hb[2]  = '{2, 2};
    int cfg_va[2]  = '{4, 40};
    int cfg_vf[2]  = '{1, 1};
    int cfg_vsy[2] = '{1, 1};
    int cfg_vb[2]  = '{1, 1};
    bit hpol[2]    = '{1'b1, 1'b0};
    bit vpol[2]    = '{1'b1, 1'b0};

    longint      t_pos[2];
    logic [1:0]  cap_mode[2];
    logic [23:0] cap_rgb[2];

    int n_vec   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int prev_fs = -1;

    typedef struct {
        logic [23:0] data;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        ls;
        int          x;
        int          y;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] pattern(input int k, input logic [1:0] m,
                                            input logic [23:0] solid, input int x, input int y);
        int idx;
        case (m)
            2'd0: return solid;
            2'd1: begin
                idx = x / (cfg_ha[k] / 8);
                case (idx)
                    0:       return 24'hFFFFFF;
                    1:       return 24'hFFFF00;
                    2:       return 24'h00FFFF;
                    3:       return 24'h00FF00;
                    4:       return 24'hFF00FF;
                    5:       return 24'hFF0000;
                    6:       return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd2: return 24'(x % 256) * 24'h010101;
            default: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    // Position is simply the number of enabled cycles since the last restart.
    task automatic model(input int k, output exp_t e);
        int     ht, vt, h, v, hs0, vs0;
        longint fr;
        ht  = cfg_hsy[k] + cfg_hb[k] + cfg_ha[k] + cfg_hf[k];
        vt  = cfg_vsy[k] + cfg_vb[k] + cfg_va[k] + cfg_vf[k];
        fr  = longint'(ht) * vt;
        hs0 = cfg_hsy[k] + cfg_hb[k];
        vs0 = cfg_vsy[k] + cfg_vb[k];
        e.data = '0;
        e.hs   = !hpol[k];
        e.vs   = !vpol[k];
        e.de   = 1'b0;
        e.fs   = 1'b0;
        e.ls   = 1'b0;
        e.x    = 0;
        e.y    = 0;
        if (!rst_n) begin
            t_pos[k]    = 0;
            cap_mode[k] = '0;
            cap_rgb[k]  = '0;
        end else if (!en) begin
            t_pos[k] = 0;
        end else begin
            h = int'(t_pos[k] % ht);
            v = int'((t_pos[k] / ht) % vt);
            if (t_pos[k] % fr == 0) begin
                cap_mode[k] = md;
                cap_rgb[k]  = rgb;
                e.fs        = 1'b1;
            end
            e.ls = (h == 0);
            e.hs = (h < cfg_hsy[k]) ? hpol[k] : !hpol[k];
            e.vs = (v < cfg_vsy[k]) ? vpol[k] : !vpol[k];
            if (h >= hs0 && h < hs0 + cfg_ha[k] && v >= vs0 && v < vs0 + cfg_va[k]) begin
                e.de   = 1'b1;
                e.x    = h - hs0;
                e.y    = v - vs0;
                e.data = pattern(k, cap_mode[k], cap_rgb[k], e.x, e.y);
            end
            t_pos[k]++;
        end
    endtask

    task automatic check_dut(input string nm, input exp_t e, input logic [23:0] d,
                             input logic hs, input logic vs, input logic de,
                             input logic [11:0] px, input logic [11:0] py,
                             input logic fs, input logic ls);
        chk({nm, ".data"},        32'(d),  32'(e.data));
        chk({nm, ".h_sync"},      32'(hs), 32'(e.hs));
        chk({nm, ".v_sync"},      32'(vs), 32'(e.vs));
        chk({nm, ".data_en"},     32'(de), 32'(e.de));
        chk({nm, ".px_x"},        32'(px), 32'(e.x));
        chk({nm, ".px_y"},        32'(py), 32'(e.y));
        chk({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
        chk({nm, ".line_start"},  32'(ls), 32'(e.ls));
    endtask

    task automatic step();
        exp_t ea, eb;
        bus_a.enable    = en;
        bus_a.mode      = md;
        bus_a.solid_rgb = rgb;
        bus_b.enable    = en;
        bus_b.mode      = md;
        bus_b.solid_rgb = rgb;
        model(0, ea);
        model(1, eb);
        @(posedge clk);
        #1;
        cyc++;
        check_dut("a", ea, bus_a.data, bus_a.h_sync, bus_a.v_sync, bus_a.data_en,
                  bus_a.px_x, bus_a.px_y, bus_a.frame_start, bus_a.line_start);
        check_dut("b", eb, bus_b.data, bus_b.h_sync, bus_b.v_sync, bus_b.data_en,
                  bus_b.px_x, bus_b.px_y, bus_b.frame_start, bus_b.line_start);
        chk("a.clk_out_hi", 32'(bus_a.clk_out), 32'd1);
        if (!rst_n || !en) begin
            prev_fs = -1;
        end else if (bus_a.frame_start) begin
            if (prev_fs >= 0) chk("a.frame_period", 32'(cyc - prev_fs), 32'd154);
            prev_fs = cyc;
        end
        @(negedge clk);
        chk("a.clk_out_lo", 32'(bus_a.clk_out), 32'd0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int act;
        rst_n = 1'b0;
        en    = 1'b0;
        md    = 2'd0;
        rgb   = 24'h0;
        run(3);
        rst_n = 1'b1;
        en    = 1'b1;
        rgb   = 24'h123456;
        run(400);
        md = 2'd1;
        run(400);
        md = 2'd2;
        run(400);
        md = 2'd3;
        run(7000);
        for (int i = 0; i < 30; i++) begin
            act = int'($urandom_range(0, 15));
            if (act == 0) begin
                rst_n = 1'b0;
                run(int'($urandom_range(1, 3)));
                rst_n = 1'b1;
            end else if (act == 1) begin
                en = 1'b0;
                run(10);
                en = 1'b1;
            end else begin
                md  = 2'($urandom_range(0, 3));
                rgb = 24'($urandom);
            end
            run(int'($urandom_range(20, 1500)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
